ddr3_axi_bram_responder: RTL and testbench

Cycle-accurate stand-in for the DDR3 IP's user-side AXI port. It answers the simplified write/read channels driven by the frame-buffer AXI master from an on-chip memory. It lets the dual-camera write path and the HDMI read path run in simulation and in DDR-less bring-up builds without the DDR3 PHY. The ports match the IP's AXI names, so the block drops in where the IP instance sits.

---
 rtl/ddr3_axi_bram_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_ddr3_axi_bram_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_axi_bram_responder.sv
// On-chip memory stand-in for the DDR3 IP's user-side AXI port.
// Same port names as the IP; answers write/read bursts from a BRAM.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   ddr_init_done            high once the init countdown has elapsed
//   axi_aw*                  write address channel (addr, len, valid/ready)
//   axi_wdata/wstrb          write beat and byte enables
//   axi_wready               beat accepted this cycle (registered)
//   axi_wusero_last          final write beat
//   axi_ar*                  read address channel (addr, len, user id, valid/ready)
//   axi_rdata/rid/rvalid/rlast  read beat channel (registered, no backpressure)
module ddr3_axi_bram_responder #(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128,
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = 64,
    parameter int RD_LATENCY  = 4,
    parameter int WR_STALL    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ddr_init_done,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic [3:0]          axi_awlen,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wready,
    output logic                axi_wusero_last,
    input  logic [ADDR_W-1:0]   axi_araddr,
    input  logic [3:0]          axi_arlen,
    input  logic [3:0]          axi_aruser_id,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic [3:0]          axi_rid,
    output logic                axi_rvalid,
    output logic                axi_rlast
);
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
    // READ-state wait cycles before the first beat is loaded
    localparam logic [7:0] DLY_INIT = 8'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam bit LAT1 = (RD_LATENCY <= 1);
    localparam bit STALL = (WR_STALL != 0);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE, S_READ} state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              prefer_rd_q, prefer_rd_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic [4:0]        rem_q, rem_d;
    logic [7:0]        dly_q, dly_d;
    logic              wready_q, wready_d;
    logic              wlast_q, wlast_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [3:0]        rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              aw_hs, ar_hs, fire;
    logic [MEM_AW-1:0] aw_idx, ar_idx, raddr;
    logic              unused_addr;

    assign aw_idx = axi_awaddr[MEM_AW+2:3];
    assign ar_idx = axi_araddr[MEM_AW+2:3];
    assign unused_addr = ^{axi_awaddr[ADDR_W-1:MEM_AW+3], axi_awaddr[2:0],
                           axi_araddr[ADDR_W-1:MEM_AW+3], axi_araddr[2:0]};

    // Round-robin arbitration: a lone valid is always granted.
    always_comb begin
        axi_awready = 1'b0;
        axi_arready = 1'b0;
        if (state_q == S_IDLE) begin
            axi_awready = ~(axi_arvalid & prefer_rd_q);
            axi_arready = ~(axi_awvalid & ~prefer_rd_q);
        end
    end

    assign aw_hs = axi_awvalid & axi_awready;
    assign ar_hs = axi_arvalid & axi_arready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        prefer_rd_d = prefer_rd_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        dly_d       = dly_q;
        rid_d       = rid_q;
        wready_d    = 1'b0;
        wlast_d     = 1'b0;
        rvalid_d    = 1'b0;
        rlast_d     = 1'b0;
        fire        = 1'b0;
        raddr       = idx_q;
        unique case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == INIT_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_IDLE: begin
                if (aw_hs) begin
                    state_d     = S_WRITE;
                    prefer_rd_d = 1'b1;
                    idx_d       = aw_idx;
                    rem_d       = {1'b0, axi_awlen};
                    wready_d    = 1'b1;
                    wlast_d     = (axi_awlen == 4'd0);
                end else if (ar_hs) begin
                    state_d     = S_READ;
                    prefer_rd_d = 1'b0;
                    rid_d       = axi_aruser_id;
                    dly_d       = DLY_INIT;
                    if (LAT1) begin
                        // first beat loads on the handshake edge itself
                        fire     = 1'b1;
                        raddr    = ar_idx;
                        idx_d    = ar_idx + MEM_AW'(1);
                        rem_d    = {1'b0, axi_arlen};
                        rvalid_d = 1'b1;
                        rlast_d  = (axi_arlen == 4'd0);
                    end else begin
                        idx_d = ar_idx;
                        rem_d = {1'b0, axi_arlen} + 5'd1;
                    end
                end
            end
            S_WRITE: begin
                // rem_q counts beats still to come after the current one
                if (wready_q) begin
                    idx_d = idx_q + MEM_AW'(1);
                    if (wlast_q) begin
                        state_d = S_IDLE;
                    end else begin
                        rem_d = rem_q - 5'd1;
                        if (!STALL) begin
                            wready_d = 1'b1;
                            wlast_d  = (rem_q == 5'd1);
                        end
                    end
                end else begin
                    wready_d = 1'b1;
                    wlast_d  = (rem_q == 5'd0);
                end
            end
            S_READ: begin
                // rem_q counts beats not yet loaded into rdata
                if (dly_q != 8'd0) begin
                    dly_d = dly_q - 8'd1;
                end else if (rem_q != 5'd0) begin
                    fire     = 1'b1;
                    idx_d    = idx_q + MEM_AW'(1);
                    rem_d    = rem_q - 5'd1;
                    rvalid_d = 1'b1;
                    rlast_d  = (rem_q == 5'd1);
                end
                if (rvalid_q && rlast_q) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            prefer_rd_q <= 1'b0;
            idx_q       <= '0;
            rem_q       <= '0;
            dly_q       <= '0;
            rid_q       <= '0;
            wready_q    <= 1'b0;
            wlast_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            prefer_rd_q <= prefer_rd_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            dly_q       <= dly_d;
            rid_q       <= rid_d;
            wready_q    <= wready_d;
            wlast_q     <= wlast_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            if (fire) begin
                rdata_q <= mem_q[raddr];
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (state_q == S_WRITE && wready_q) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_wstrb[b]) begin
                    mem_q[idx_q][8*b +: 8] <= axi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ddr_init_done   = done_q;
    assign axi_wready      = wready_q;
    assign axi_wusero_last = wlast_q;
    assign axi_rdata       = rdata_q;
    assign axi_rid         = rid_q;
    assign axi_rvalid      = rvalid_q;
    assign axi_rlast       = rlast_q;

endmodule

// File: tb/tb_ddr3_axi_bram_responder.sv
// Bench for ddr3_axi_bram_responder: table of write/read records
// checked through a reference memory and a read-beat scoreboard.
module tb_ddr3_axi_bram_responder;
    localparam int RD_LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, rst_b, sel;
    logic [27:0]  awaddr, araddr;
    logic [3:0]   awlen, arlen, arid;
    logic         awvalid, arvalid;
    logic [127:0] wdata;
    logic [15:0]  wstrb;

    logic done_a, awready_a, arready_a, wready_a, wlast_a, rvalid_a, rlast_a;
    logic done_b, awready_b, arready_b, wready_b, wlast_b, rvalid_b, rlast_b;
    logic [3:0]   rid_a, rid_b;
    logic [127:0] rdata_a, rdata_b;

    ddr3_axi_bram_responder #(.WR_STALL(0)) dut (
        .clk(clk), .rst_n(rst_a), .ddr_init_done(done_a),
        .axi_awaddr(awaddr), .axi_awlen(awlen),
        .axi_awvalid(awvalid), .axi_awready(awready_a),
        .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_wready(wready_a), .axi_wusero_last(wlast_a),
        .axi_araddr(araddr), .axi_arlen(arlen), .axi_aruser_id(arid),
        .axi_arvalid(arvalid), .axi_arready(arready_a),
        .axi_rdata(rdata_a), .axi_rid(rid_a),
        .axi_rvalid(rvalid_a), .axi_rlast(rlast_a)
    );

    ddr3_axi_bram_responder #(.WR_STALL(1)) dut_s (
        .clk(clk), .rst_n(rst_b), .ddr_init_done(done_b),
        .axi_awaddr(awaddr), .axi_awlen(awlen),
        .axi_awvalid(awvalid), .axi_awready(awready_b),
        .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_wready(wready_b), .axi_wusero_last(wlast_b),
        .axi_araddr(araddr), .axi_arlen(arlen), .axi_aruser_id(arid),
        .axi_arvalid(arvalid), .axi_arready(arready_b),
        .axi_rdata(rdata_b), .axi_rid(rid_b),
        .axi_rvalid(rvalid_b), .axi_rlast(rlast_b)
    );

    logic m_done, m_awready, m_arready, m_wready, m_wlast, m_rvalid, m_rlast;
    logic [3:0]   m_rid;
    logic [127:0] m_rdata;
    assign m_done    = sel ? done_b    : done_a;
    assign m_awready = sel ? awready_b : awready_a;
    assign m_arready = sel ? arready_b : arready_a;
    assign m_wready  = sel ? wready_b  : wready_a;
    assign m_wlast   = sel ? wlast_b   : wlast_a;
    assign m_rvalid  = sel ? rvalid_b  : rvalid_a;
    assign m_rlast   = sel ? rlast_b   : rlast_a;
    assign m_rid     = sel ? rid_b     : rid_a;
    assign m_rdata   = sel ? rdata_b   : rdata_a;

    int total = 0;
    int bad = 0;
    logic [127:0] ref_m [2][1024];
    logic [127:0] sbq [$];

    typedef struct {
        bit           do_w;
        logic [27:0]  waddr;
        logic [3:0]   wlen;
        logic [15:0]  wstrb;
        logic [31:0]  base;
        logic [27:0]  raddr;
        logic [3:0]   rlen;
        logic [3:0]   rid;
        logic [127:0] exp_first;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!m_done && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk(nm, 128'(m_done), 128'd1);
    endtask

    task automatic wr(input logic [27:0] addr, input logic [3:0] len,
                      input logic [15:0] strb, input logic [31:0] base,
                      input int abort_at, output logic [31:0] pat);
        int k, b;
        bit lok, bok;
        logic [9:0] idx;
        logic [127:0] d;
        pat = '0; lok = 1; bok = 1; b = 0;
        awaddr = addr; awlen = len; awvalid = 1'b1;
        #1;
        k = 0;
        while (!m_awready && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        chk("aw_grant", 128'(m_awready), 128'd1);
        if (!m_awready) begin
            awvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        k = 0;
        while (b <= int'(len) && k < 64) begin
            pat = {pat[30:0], m_wready};
            bok &= !m_awready & !m_arready;
            if (m_wready) begin
                if (b == abort_at) begin
                    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
                    #1;
                    chk("rst_ctl", 128'({m_done, m_awready, m_arready, m_wready,
                        m_wlast, m_rvalid, m_rlast, m_rid}), 128'd0);
                    chk("rst_rdata", m_rdata, 128'd0);
                    wstrb = '0;
                    return;
                end
                d = {4{base + 32'(b)}};
                wdata = d;
                wstrb = strb;
                idx = addr[12:3] + 10'(b);
                for (int j = 0; j < 16; j++)
                    if (strb[j]) ref_m[sel][idx][8*j +: 8] = d[8*j +: 8];
                lok &= (m_wlast == (b == int'(len)));
                b++;
            end else begin
                lok &= !m_wlast;
            end
            @(posedge clk); #1;
            k++;
        end
        wstrb = '0;
        chk("wr_beats", 128'(b), 128'(int'(len) + 1));
        chk("wr_last", 128'(lok), 128'd1);
        chk("wr_busy", 128'(bok), 128'd1);
        chk("wr_idle_after", 128'({m_awready, m_wready}), 128'b10);
    endtask

    task automatic rd(input logic [27:0] addr, input logic [3:0] len,
                      input logic [3:0] id, input logic [127:0] exp_first);
        int k, n, first;
        bit cont, lst, bok;
        logic [9:0] idx;
        logic [127:0] e;
        sbq.delete();
        for (int b = 0; b <= int'(len); b++) begin
            idx = addr[12:3] + 10'(b);
            sbq.push_back(ref_m[sel][idx]);
        end
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        #1;
        k = 0;
        while (!m_arready && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        chk("ar_grant", 128'(m_arready), 128'd1);
        if (!m_arready) begin
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        k = 1; n = 0; first = -1; cont = 1; lst = 1; bok = 1;
        while (n <= int'(len) && k < 64) begin
            bok &= !m_awready & !m_arready;
            if (m_rvalid) begin
                if (first < 0) begin
                    first = k;
                    chk("rd_first_beat", m_rdata, exp_first);
                end
                cont &= ((k - first) == n);
                e = sbq.pop_front();
                chk("rd_data", m_rdata, e);
                chk("rd_id", 128'(m_rid), 128'(id));
                lst &= (m_rlast == (n == int'(len)));
                n++;
            end else begin
                cont &= (first < 0);
                lst &= !m_rlast;
            end
            @(posedge clk); #1;
            k++;
        end
        chk("rd_latency", 128'(first), 128'(RD_LAT));
        chk("rd_beats", 128'(n), 128'(int'(len) + 1));
        chk("rd_contig", 128'(cont), 128'd1);
        chk("rd_last", 128'(lst), 128'd1);
        chk("rd_busy", 128'(bok), 128'd1);
        chk("rd_idle_after", 128'({m_awready, m_rvalid}), 128'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] pat;
        bit pre_ok;
        bit gr [4];
        int g, k;

        tbl[0] = '{1'b1, 28'h0000100, 4'd15, 16'hFFFF, 32'h0,
                   28'h0000100, 4'd15, 4'hA, 128'h0};
        tbl[1] = '{1'b1, 28'h0000028, 4'd0, 16'hFFFF, 32'hFFFF_FFFF,
                   28'h0000028, 4'd0, 4'h1, {4{32'hFFFF_FFFF}}};
        tbl[2] = '{1'b1, 28'h0000028, 4'd0, 16'h00FF, 32'h0,
                   28'h0000028, 4'd0, 4'h2,
                   128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000};
        tbl[3] = '{1'b1, 28'h0001FF0, 4'd3, 16'hFFFF, 32'h1000_0000,
                   28'h0000000, 4'd1, 4'h3, {4{32'h1000_0002}}};
        tbl[4] = '{1'b0, 28'h0, 4'd0, 16'h0, 32'h0,
                   28'h0003FF0, 4'd3, 4'h5, {4{32'h1000_0000}}};
        tbl[5] = '{1'b1, 28'h00020CB, 4'd1, 16'hFFFF, 32'hCAFE_0000,
                   28'h00000C8, 4'd1, 4'h6, {4{32'hCAFE_0000}}};
        tbl[6] = '{1'b0, 28'h0, 4'd0, 16'h0, 32'h0,
                   28'h0001FF8, 4'd2, 4'h7, {4{32'h1000_0001}}};

        for (int i = 0; i < 1024; i++) begin
            ref_m[0][i] = '0;
            ref_m[1][i] = '0;
        end

        rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
        awaddr = '0; awlen = '0; araddr = '0; arlen = '0; arid = '0;
        wdata = '0; wstrb = '0; arvalid = 1'b0;
        awvalid = 1'b1;

        #12;
        chk("reset_ctl", 128'({done_a, awready_a, arready_a, wready_a,
            wlast_a, rvalid_a, rlast_a, rid_a}), 128'd0);
        chk("reset_rdata", rdata_a, 128'd0);
        #10;
        rst_a = 1'b1;
        pre_ok = 1;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            if (c < 64) begin
                pre_ok &= !m_done & !m_awready;
            end else begin
                chk("init_quiet", 128'(pre_ok), 128'd1);
                chk("init_done_64", 128'(m_done), 128'd1);
                chk("init_awready", 128'(m_awready), 128'd1);
                awvalid = 1'b0;
            end
        end

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_w) begin
                wr(tbl[i].waddr, tbl[i].wlen, tbl[i].wstrb, tbl[i].base, -1, pat);
                chk("wr_pat", 128'(pat),
                    128'((32'd1 << (int'(tbl[i].wlen) + 1)) - 32'd1));
            end
            rd(tbl[i].raddr, tbl[i].rlen, tbl[i].rid, tbl[i].exp_first);
        end

        @(posedge clk); #1;
        rst_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b1;
        wait_done("reinit_done");
        awaddr = 28'h0000400; awlen = '0;
        araddr = 28'h0000400; arlen = '0;
        wstrb = '0;
        awvalid = 1'b1; arvalid = 1'b1;
        g = 0; k = 0;
        while (g < 4 && k < 200) begin
            #1;
            if (m_awready) begin
                gr[g] = 1'b0; g++;
            end else if (m_arready) begin
                gr[g] = 1'b1; g++;
            end
            if (g == 4) begin
                awvalid = 1'b0; arvalid = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        awvalid = 1'b0; arvalid = 1'b0;
        chk("rr_count", 128'(g), 128'd4);
        chk("rr_grant0_w", 128'(gr[0]), 128'd0);
        chk("rr_grant1_r", 128'(gr[1]), 128'd1);
        chk("rr_grant2_w", 128'(gr[2]), 128'd0);
        chk("rr_grant3_r", 128'(gr[3]), 128'd1);
        rd(28'h0000108, 4'd0, 4'hC, {4{32'h1}});

        @(posedge clk); #1;
        rst_a = 1'b0;
        sel = 1'b1;
        rst_b = 1'b1;
        wait_done("stall_init");
        wr(28'h0000140, 4'd3, 16'hFFFF, 32'h5A5A_0000, -1, pat);
        chk("stall_pat", 128'(pat), 128'h55);
        wr(28'h00001E0, 4'd3, 16'hFFFF, 32'h7777_0000, 2, pat);
        @(posedge clk); #1;
        rst_b = 1'b1;
        wait_done("stall_reinit");
        rd(28'h0000140, 4'd3, 4'h9, {4{32'h5A5A_0000}});
        rd(28'h00001E0, 4'd1, 4'h4, {4{32'h7777_0000}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
